// File: rtl/gate_drive_sequencer.sv
// Gate drive sequencer: arms one three-phase drive through a bootstrap precharge,
// supervises the software watchdog and latches drive faults with all gates off
// until software explicitly clears them.
module gate_drive_sequencer #(
    parameter int PHASES      = 3,
    parameter int BOOT_CYCLES = 2500,
    parameter int WDT_CYCLES  = 500000,
    parameter int CNT_W       = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm_req,
    input  logic              kick,
    input  logic              fault_clr,
    input  logic              ext_fault_n,
    input  logic [PHASES-1:0] pwm_udrive_in,
    input  logic [PHASES-1:0] pwm_ldrive_in,
    output logic [PHASES-1:0] udrive_out,
    output logic [PHASES-1:0] ldrive_out,
    output logic [1:0]        state,
    output logic [1:0]        fault_code,
    output logic              armed
);

    typedef enum logic [1:0] {
        ST_DISARMED  = 2'd0,
        ST_BOOTSTRAP = 2'd1,
        ST_ARMED     = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE  = 2'd0,
        FC_WDT   = 2'd1,
        FC_EXT   = 2'd2,
        FC_SHOOT = 2'd3
    } fault_t;

    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    state_t            r_state;
    fault_t            r_fault_code;
    logic [CNT_W-1:0]  r_boot_cnt;
    logic [CNT_W-1:0]  r_wdt_cnt;
    logic [PHASES-1:0] r_udrive;
    logic [PHASES-1:0] r_ldrive;
    logic              r_armed;

    logic              w_ext_flt;
    logic [PHASES-1:0] w_overlap;
    logic              w_shoot;
    logic              w_wdt_expire;
    logic              w_boot_done;
    logic [CNT_W-1:0]  w_wdt_next;

    assign w_ext_flt    = ~r_sync2;
    assign w_overlap    = pwm_udrive_in & pwm_ldrive_in;
    assign w_shoot      = |w_overlap;
    assign w_wdt_expire = (r_wdt_cnt == WDT_LAST) && !kick;
    assign w_boot_done  = (r_boot_cnt == BOOT_LAST);
    assign w_wdt_next   = kick ? '0 : r_wdt_cnt + CNT_W'(1);

    assign udrive_out = r_udrive;
    assign ldrive_out = r_ldrive;
    assign state      = r_state;
    assign fault_code = r_fault_code;
    assign armed      = r_armed;

    // Two-flop synchroniser for the asynchronous driver fault pin; idles at "no fault".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= ext_fault_n;
            r_sync2 <= r_sync1;
        end
    end

    // Arming FSM; gate outputs are registered from the state being entered, so
    // every transition into DISARMED or FAULT lands with all gates already off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_DISARMED;
            r_fault_code <= FC_NONE;
            r_boot_cnt   <= '0;
            r_wdt_cnt    <= '0;
            r_udrive     <= '0;
            r_ldrive     <= '0;
            r_armed      <= 1'b0;
        end else begin
            r_udrive <= '0;
            r_ldrive <= '0;
            r_armed  <= 1'b0;
            case (r_state)
                ST_DISARMED: begin
                    if (w_ext_flt) begin
                        r_state      <= ST_FAULT;
                        r_fault_code <= FC_EXT;
                    end else if (arm_req) begin
                        r_state    <= ST_BOOTSTRAP;
                        r_boot_cnt <= '0;
                        r_wdt_cnt  <= '0;
                        r_ldrive   <= '1;
                    end
                end
                ST_BOOTSTRAP: begin
                    r_wdt_cnt <= w_wdt_next;
                    if (w_ext_flt) begin
                        r_state      <= ST_FAULT;
                        r_fault_code <= FC_EXT;
                    end else if (w_wdt_expire) begin
                        r_state      <= ST_FAULT;
                        r_fault_code <= FC_WDT;
                    end else if (!arm_req) begin
                        r_state <= ST_DISARMED;
                    end else if (w_boot_done) begin
                        // Shoot-through detection only starts in ARMED, so any phase with
                        // conflicting demand on the arming edge is simply held off.
                        r_state  <= ST_ARMED;
                        r_armed  <= 1'b1;
                        r_udrive <= pwm_udrive_in & ~w_overlap;
                        r_ldrive <= pwm_ldrive_in & ~w_overlap;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + CNT_W'(1);
                        r_ldrive   <= '1;
                    end
                end
                ST_ARMED: begin
                    r_wdt_cnt <= w_wdt_next;
                    if (w_ext_flt) begin
                        r_state      <= ST_FAULT;
                        r_fault_code <= FC_EXT;
                    end else if (w_shoot) begin
                        r_state      <= ST_FAULT;
                        r_fault_code <= FC_SHOOT;
                    end else if (w_wdt_expire) begin
                        r_state      <= ST_FAULT;
                        r_fault_code <= FC_WDT;
                    end else if (!arm_req) begin
                        r_state <= ST_DISARMED;
                    end else begin
                        r_armed  <= 1'b1;
                        r_udrive <= pwm_udrive_in;
                        r_ldrive <= pwm_ldrive_in;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr && !arm_req && !w_ext_flt) begin
                        r_state      <= ST_DISARMED;
                        r_fault_code <= FC_NONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_drive_sequencer.sv
// Self-checking bench for gate_drive_sequencer: directed arming/fault scenarios
// followed by a randomized soak, scored against a cycle-level reference model.
module tb_gate_drive_sequencer;

    localparam int PHASES = 3;
    localparam int BOOT   = 4;
    localparam int WDT    = 16;

    logic             clk;
    logic             reset_n;
    logic             arm_req;
    logic             kick;
    logic             fault_clr;
    logic             ext_fault_n;
    logic [PHASES-1:0] pwm_udrive_in;
    logic [PHASES-1:0] pwm_ldrive_in;
    logic [PHASES-1:0] udrive_out;
    logic [PHASES-1:0] ldrive_out;
    logic [1:0]       state;
    logic [1:0]       fault_code;
    logic             armed;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] code;
        logic       arm;
        logic [2:0] u;
        logic [2:0] l;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   compared   = 0;
    int   mismatched = 0;
    int   cycleNo    = 0;
    bit   summaryDone = 0;

    int   mState;
    int   mCode;
    int   mBoot;
    int   mSince;
    bit   mHist0;
    bit   mHist1;

    gate_drive_sequencer #(
        .PHASES(PHASES),
        .BOOT_CYCLES(BOOT),
        .WDT_CYCLES(WDT),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .arm_req(arm_req),
        .kick(kick),
        .fault_clr(fault_clr),
        .ext_fault_n(ext_fault_n),
        .pwm_udrive_in(pwm_udrive_in),
        .pwm_ldrive_in(pwm_ldrive_in),
        .udrive_out(udrive_out),
        .ldrive_out(ldrive_out),
        .state(state),
        .fault_code(fault_code),
        .armed(armed)
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model reset: disarmed, no fault, fault pin history reads "no fault".
    function automatic void modelReset();
        mState = 0;
        mCode  = 0;
        mBoot  = 0;
        mSince = 0;
        mHist0 = 1'b1;
        mHist1 = 1'b1;
    endfunction

    // One clock edge of the reference model, written from the behavioural rules:
    // cycles spent bootstrapping, cycles since the last kick, and the fault pin
    // as seen two edges late. Returns the outputs expected after the edge.
    function automatic exp_t modelStep(input bit a, input bit k, input bit c, input bit en,
                                       input bit [2:0] u, input bit [2:0] l);
        exp_t     r;
        bit       extFlt;
        bit       conflict;
        bit       wdtTrip;
        bit [2:0] bad;
        int       nxt;
        extFlt   = !mHist0;
        mHist0   = mHist1;
        mHist1   = en;
        bad      = u & l;
        conflict = (bad != 3'b000);
        nxt      = mState;
        wdtTrip  = 1'b0;
        if (mState == 1 || mState == 2) begin
            mSince  = k ? 0 : mSince + 1;
            wdtTrip = (mSince >= WDT);
        end
        case (mState)
            0: begin
                if (extFlt) begin nxt = 3; mCode = 2; end
                else if (a) begin nxt = 1; mBoot = 0; mSince = 0; end
            end
            1: begin
                mBoot++;
                if (extFlt) begin nxt = 3; mCode = 2; end
                else if (wdtTrip) begin nxt = 3; mCode = 1; end
                else if (!a) nxt = 0;
                else if (mBoot >= BOOT) nxt = 2;
            end
            2: begin
                if (extFlt) begin nxt = 3; mCode = 2; end
                else if (conflict) begin nxt = 3; mCode = 3; end
                else if (wdtTrip) begin nxt = 3; mCode = 1; end
                else if (!a) nxt = 0;
            end
            default: begin
                if (c && !a && !extFlt) begin nxt = 0; mCode = 0; end
            end
        endcase
        mState = nxt;
        r.st   = 2'(nxt);
        r.code = 2'(mCode);
        r.arm  = (nxt == 2);
        r.u    = (nxt == 2) ? (u & ~bad) : 3'b000;
        r.l    = (nxt == 1) ? 3'b111 : ((nxt == 2) ? (l & ~bad) : 3'b000);
        return r;
    endfunction

    // Drive one cycle of inputs on the falling edge and queue the model's prediction.
    task automatic applyStimulus(input bit a, input bit k, input bit c, input bit en,
                                 input bit [2:0] u, input bit [2:0] l);
        @(negedge clk);
        arm_req       = a;
        kick          = k;
        fault_clr     = c;
        ext_fault_n   = en;
        pwm_udrive_in = u;
        pwm_ldrive_in = l;
        expQ.push_back(modelStep(a, k, c, en, u, l));
    endtask

    // Compare DUT outputs to an expected record; also rejects any phase with both gates on.
    task automatic checkOutput(input exp_t e, input string name);
        exp_t got;
        got = {state, fault_code, armed, udrive_out, ldrive_out};
        compared++;
        if (got !== e || (udrive_out & ldrive_out) != 3'b000) begin
            mismatched++;
            $display("[TB] FAIL %s: got state=%0d code=%0d armed=%0d u=%b l=%b, expected state=%0d code=%0d armed=%0d u=%b l=%b",
                     name, state, fault_code, armed, udrive_out, ldrive_out,
                     e.st, e.code, e.arm, e.u, e.l);
        end
    endtask

    // Random PWM demand with no phase asking for both switches.
    task automatic rndSafe(output bit [2:0] u, output bit [2:0] l);
        u = 3'($urandom_range(0, 7));
        l = 3'($urandom_range(0, 7)) & ~u;
    endtask

    task automatic printSummary();
        if (!summaryDone) begin
            summaryDone = 1'b1;
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        end
    endtask

    // Monitor: just after each rising edge, pop the pending prediction and score it.
    always @(posedge clk) begin
        #1;
        if (reset_n && expQ.size() > 0) begin
            monExp = expQ.pop_front();
            cycleNo++;
            checkOutput(monExp, $sformatf("cycle_%0d", cycleNo));
        end
    end

    // Watchdog on the bench itself so a stuck run still reports.
    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: run did not finish, got still running, expected done");
        mismatched++;
        printSummary();
        $finish;
    end

    // Directed scenarios, randomized soak, then drain and summary.
    initial begin
        bit [2:0] u;
        bit [2:0] l;
        exp_t     zero;
        bit       aR;
        bit       eR;
        int       armHold;
        int       eHold;
        zero          = '0;
        reset_n       = 1'b0;
        arm_req       = 1'b0;
        kick          = 1'b0;
        fault_clr     = 1'b0;
        ext_fault_n   = 1'b1;
        pwm_udrive_in = '0;
        pwm_ldrive_in = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput(zero, "reset_state");
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        $display("[TB] arm sequence");
        for (int i = 0; i < 30; i++) begin
            if (i < 8) begin u = 3'b101; l = 3'b010; end
            else rndSafe(u, l);
            applyStimulus(1'b1, (i % 8) == 2, 1'b0, 1'b1, u, l);
        end

        $display("[TB] watchdog expiry");
        for (int i = 0; i < 24; i++) begin
            rndSafe(u, l);
            applyStimulus(1'b1, i == 20, 1'b0, 1'b1, u, l);
        end

        $display("[TB] clear rules");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b0, i == 3, 1'b0, 3'b000, 3'b000);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000);

        $display("[TB] re-arm then shoot-through");
        for (int i = 0; i < 12; i++) begin
            rndSafe(u, l);
            applyStimulus(1'b1, (i % 4) == 0, 1'b0, 1'b1, u, l);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 3'b001);
        for (int i = 0; i < 3; i++) begin
            rndSafe(u, l);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, u, l);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000);

        $display("[TB] external fault racing shoot-through");
        for (int i = 0; i < 10; i++) begin
            rndSafe(u, l);
            applyStimulus(1'b1, (i % 4) == 0, 1'b0, 1'b1, u, l);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin u = 3'b110; l = 3'b010; end
            else rndSafe(u, l);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, u, l);
        end
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000);

        $display("[TB] bootstrap abort");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'b011, 3'b100);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 3'b100);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000);

        $display("[TB] async reset while armed");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, (i % 4) == 0, 1'b0, 1'b1, 3'b111, 3'b000);
        end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput(zero, "async_reset");
        arm_req = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput(zero, "reset_hold");
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000);

        $display("[TB] random soak");
        aR      = 1'b0;
        eR      = 1'b1;
        armHold = 0;
        eHold   = 0;
        for (int i = 0; i < 1500; i++) begin
            if (armHold == 0) begin
                aR      = !aR;
                armHold = aR ? $urandom_range(3, 60) : $urandom_range(1, 8);
            end
            armHold--;
            if (eHold == 0) begin
                eR    = ($urandom_range(0, 9) != 0);
                eHold = $urandom_range(1, 6);
            end
            eHold--;
            if ($urandom_range(0, 19) == 0) begin
                u = 3'($urandom_range(0, 7));
                l = 3'($urandom_range(0, 7));
            end else begin
                rndSafe(u, l);
            end
            applyStimulus(aR, $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0, eR, u, l);
        end

        repeat (3) @(posedge clk);
        #2;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL queue_drain: got %0d pending, expected 0", expQ.size());
        end
        printSummary();
        $finish;
    end

endmodule
